// File: rtl/fetch_unit.sv
// fetch_unit: program-counter sequencer with a registered fetch queue, redirect flush and sticky fault.
// Optional counters perf_fetched/perf_stall are built when FETCH_PERF_EN is defined.
module fetch_unit #(
    parameter int          MEM_BYTES = 88,
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          QDEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] inst_address,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc,
    output logic        fault,
    output logic [63:0] fault_pc,
    output logic        dbg_state_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int              PW       = $clog2(QDEPTH);
    localparam int              CW       = PW + 1;
    localparam logic [63:0]     LAST_PC  = 64'(MEM_BYTES - 4);
    localparam logic [CW-1:0]   FULL_CNT = CW'(QDEPTH);

    typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_e;

    state_e        state_q, state_d;
    logic          fetch_en;

    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [95:0]   qmem_q [QDEPTH];
    logic [95:0]   head_q, head_d;
    logic          fault_q, fault_d;
    logic [63:0]   fault_pc_q, fault_pc_d;

    logic          legal, deq, room, enq, fault_set;

    // out_valid/out_ready: a transfer happens on every edge where both are high;
    // out_valid is a register and never depends on out_ready.
    assign out_valid    = (count_q != '0);
    assign deq          = out_valid & out_ready;
    assign legal        = (fetch_pc_q[1:0] == 2'b00) && (fetch_pc_q <= LAST_PC);
    assign room         = (count_q < FULL_CNT) | deq;
    assign enq          = fetch_en & legal & room & ~redirect_valid;
    assign fault_set    = fetch_en & ~legal & ~redirect_valid;

    assign inst_address = fetch_pc_q;
    assign out_inst     = head_q[31:0];
    assign out_pc       = head_q[95:32];
    assign fault        = fault_q;
    assign fault_pc     = fault_pc_q;
    assign dbg_state_o  = state_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = S_RUN;
        end else if (state_q == S_RUN && !legal) begin
            state_d = S_HALT;
        end
    end

    always_comb begin
        fetch_en = (state_q == S_RUN);
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fault_d    = 1'b0;
        end else begin
            if (enq) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
                wr_ptr_d   = wr_ptr_q + PW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (enq && !deq) begin
                count_d = count_q + CW'(1);
            end else if (!enq && deq) begin
                count_d = count_q - CW'(1);
            end
            if (fault_set) begin
                fault_d    = 1'b1;
                fault_pc_d = fetch_pc_q;
            end
        end
    end

    // The head register holds its last value when the queue goes empty; when the
    // entry being written becomes the head, it is taken straight from the fetch.
    always_comb begin
        head_d = head_q;
        if (count_d != '0) begin
            if (enq && rd_ptr_d == wr_ptr_q) begin
                head_d = {fetch_pc_q, instruction};
            end else begin
                head_d = qmem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            head_q     <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                qmem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            head_q     <= head_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            if (enq) begin
                qmem_q[wr_ptr_q] <= {fetch_pc_q, instruction};
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_stall_q;
    logic        stall;

    assign stall        = fetch_en & legal & ~redirect_valid & ~room;
    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (enq && perf_fetched_q != 32'hFFFF_FFFF) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (stall && perf_stall_q != 32'hFFFF_FFFF) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end
`endif

endmodule
